// File: rtl/cls_vote_unit.sv
// N-way lockstep voter/checker: bitwise-majority vote over redundant channel
// bundles, persistence-filtered fault confirmation and halt on lost majority.
module cls_vote_unit #(
  parameter int unsigned N_CH           = 3,
  parameter int unsigned W              = 72,
  parameter int unsigned CONFIRM_CYCLES = 2,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic [N_CH*W-1:0]     ch_bus_i,
  output logic [W-1:0]          voted_o,
  output logic                  mismatch_o,
  output logic [N_CH-1:0]       dis_mask_o,
  output logic                  fault_o,
  output logic [N_CH-1:0]       fault_ch_o,
  output logic                  halt_o,
  output logic [1:0]            state_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o
);

  localparam int unsigned PW = $clog2(CONFIRM_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SUSPECT = 2'd1,
    FAULT   = 2'd2,
    HALT    = 2'd3
  } state_t;

  if ((N_CH < 3) || ((N_CH % 2) == 0)) begin : g_bad_nch
    $error("cls_vote_unit: N_CH must be odd and >= 3");
  end
  if (CONFIRM_CYCLES < 1) begin : g_bad_confirm
    $error("cls_vote_unit: CONFIRM_CYCLES must be >= 1");
  end

  state_t              r_state;
  logic [W-1:0]        r_voted;
  logic                r_mismatch;
  logic [N_CH-1:0]     r_dis_mask;
  logic                r_fault;
  logic [N_CH-1:0]     r_fault_ch;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [PW-1:0]       r_persist;
  logic [N_CH-1:0]     r_last_mask;

  logic [W-1:0]        w_maj;
  logic [N_CH-1:0]     w_mask;
  logic                w_uncorr;
  logic [N_CH-1:0]     w_eval;
  logic [PW-1:0]       w_run_cnt;
  logic                w_confirm;

  always_comb begin
    int unsigned cnt;
    int unsigned dis;
    w_maj    = '0;
    w_mask   = '0;
    w_uncorr = 1'b0;
    for (int unsigned b = 0; b < W; b++) begin
      cnt = 0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (ch_bus_i[k*W + b]) cnt++;
      end
      w_maj[b] = (cnt > N_CH / 2);
    end
    dis = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_mask[k] = (ch_bus_i[k*W +: W] != w_maj);
      if (w_mask[k]) dis++;
    end
    w_uncorr = (dis > N_CH / 2);
  end

  // RUN and SUSPECT share the FAULT persistence rule: in RUN the run state is
  // zero, so any nonzero mask simply starts a fresh run of length one.
  always_comb begin
    w_eval    = (r_state == FAULT) ? (w_mask & ~r_fault_ch) : w_mask;
    w_run_cnt = ((w_eval == r_last_mask) && (r_persist != '0)) ?
                (r_persist + PW'(1)) : PW'(1);
    w_confirm = (w_eval != '0) && (w_run_cnt >= PW'(CONFIRM_CYCLES));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= RUN;
      r_voted     <= '0;
      r_mismatch  <= 1'b0;
      r_dis_mask  <= '0;
      r_fault     <= 1'b0;
      r_fault_ch  <= '0;
      r_err_cnt   <= '0;
      r_persist   <= '0;
      r_last_mask <= '0;
    end else begin
      if (en_i && (r_state != HALT)) begin
        r_voted    <= w_maj;
        r_mismatch <= (w_mask != '0);
        r_dis_mask <= w_mask;
      end
      if (clear_i) begin
        r_state     <= RUN;
        r_fault     <= 1'b0;
        r_fault_ch  <= '0;
        r_persist   <= '0;
        r_last_mask <= '0;
      end else if (en_i && (r_state != HALT)) begin
        if (w_uncorr) begin
          r_state <= HALT;
        end else if (w_eval == '0) begin
          r_persist   <= '0;
          r_last_mask <= '0;
          if (r_state == SUSPECT) r_state <= RUN;
        end else if (w_confirm) begin
          r_state     <= FAULT;
          r_fault     <= 1'b1;
          r_fault_ch  <= r_fault_ch | w_eval;
          r_persist   <= '0;
          r_last_mask <= '0;
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        end else begin
          r_persist   <= w_run_cnt;
          r_last_mask <= w_eval;
          if (r_state != FAULT) r_state <= SUSPECT;
        end
      end
    end
  end

  assign voted_o    = r_voted;
  assign mismatch_o = r_mismatch;
  assign dis_mask_o = r_dis_mask;
  assign fault_o    = r_fault;
  assign fault_ch_o = r_fault_ch;
  assign halt_o     = (r_state == HALT);
  assign state_o    = r_state;
  assign err_cnt_o  = r_err_cnt;

endmodule

// File: tb/tb_cls_vote_unit.sv
// Directed-vector bench for cls_vote_unit: 3 channels of 8 bits, confirm after
// two cycles, 2-bit error counter so saturation is reachable.
module tb_cls_vote_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [23:0] bus;
  logic [7:0]  voted;
  logic        mism;
  logic [2:0]  dmask;
  logic        fault;
  logic [2:0]  fch;
  logic        halt;
  logic [1:0]  state;
  logic [1:0]  errc;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  cls_vote_unit #(
    .N_CH(3),
    .W(8),
    .CONFIRM_CYCLES(2),
    .ERR_CNT_W(2)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .en_i(en),
    .clear_i(clr),
    .ch_bus_i(bus),
    .voted_o(voted),
    .mismatch_o(mism),
    .dis_mask_o(dmask),
    .fault_o(fault),
    .fault_ch_o(fch),
    .halt_o(halt),
    .state_o(state),
    .err_cnt_o(errc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                     input logic e, input logic c);
    bus = {c2, c1, c0};
    en  = e;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_voted"}, 32'(voted), 32'h00);
    chk({tag, "_mism"},  32'(mism),  32'h0);
    chk({tag, "_dmask"}, 32'(dmask), 32'h0);
    chk({tag, "_fault"}, 32'(fault), 32'h0);
    chk({tag, "_fch"},   32'(fch),   32'h0);
    chk({tag, "_halt"},  32'(halt),  32'h0);
    chk({tag, "_state"}, 32'(state), 32'h0);
    chk({tag, "_errc"},  32'(errc),  32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    clr   = 1'b0;
    bus   = {8'h5A, 8'h3C, 8'hFF};
    cyc(8'hFF, 8'h3C, 8'h5A, 1'b1, 1'b0);
    cyc(8'hFF, 8'h3C, 8'h5A, 1'b1, 1'b0);
    chk_reset("rst0");
    rst_n = 1'b1;

    // T1: unanimous channels
    for (int i = 0; i < 10; i++) begin
      cyc(8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b0);
      chk("t1_voted", 32'(voted), 32'hA5);
      chk("t1_mism",  32'(mism),  32'h0);
      chk("t1_state", 32'(state), 32'h0);
    end

    // T2: single-cycle transient on ch1
    cyc(8'hA5, 8'hA4, 8'hA5, 1'b1, 1'b0);
    chk("t2_dmask", 32'(dmask), 32'h2);
    chk("t2_mism",  32'(mism),  32'h1);
    chk("t2_voted", 32'(voted), 32'hA5);
    chk("t2_susp",  32'(state), 32'h1);
    cyc(8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b0);
    chk("t2_run",   32'(state), 32'h0);
    chk("t2_fault", 32'(fault), 32'h0);
    chk("t2_errc",  32'(errc),  32'h0);

    // T3: persistent ch2 fault
    cyc(8'h11, 8'h11, 8'h00, 1'b1, 1'b0);
    chk("t3_susp",   32'(state), 32'h1);
    chk("t3_fault1", 32'(fault), 32'h0);
    chk("t3_voted1", 32'(voted), 32'h11);
    cyc(8'h11, 8'h11, 8'h00, 1'b1, 1'b0);
    chk("t3_state",  32'(state), 32'h2);
    chk("t3_fault",  32'(fault), 32'h1);
    chk("t3_fch",    32'(fch),   32'h4);
    chk("t3_errc",   32'(errc),  32'h1);
    chk("t3_voted2", 32'(voted), 32'h11);
    cyc(8'h11, 8'h11, 8'h00, 1'b1, 1'b0);
    chk("t3_norecnt", 32'(errc), 32'h1);
    chk("t3_stay",    32'(state), 32'h2);
    cyc(8'h11, 8'h11, 8'h11, 1'b1, 1'b0);
    chk("t3_stay2",   32'(state), 32'h2);

    // T4: no majority -> HALT, then clear
    cyc(8'h01, 8'h02, 8'h04, 1'b1, 1'b0);
    chk("t4_state", 32'(state), 32'h3);
    chk("t4_halt",  32'(halt),  32'h1);
    chk("t4_voted", 32'(voted), 32'h00);
    chk("t4_dmask", 32'(dmask), 32'h7);
    cyc(8'h55, 8'h55, 8'h55, 1'b1, 1'b0);
    chk("t4_frz_voted", 32'(voted), 32'h00);
    chk("t4_frz_dmask", 32'(dmask), 32'h7);
    chk("t4_frz_state", 32'(state), 32'h3);
    cyc(8'h55, 8'h55, 8'h55, 1'b1, 1'b1);
    chk("t4_clr_state", 32'(state), 32'h0);
    chk("t4_clr_halt",  32'(halt),  32'h0);
    chk("t4_clr_fault", 32'(fault), 32'h0);
    chk("t4_clr_fch",   32'(fch),   32'h0);
    chk("t4_clr_errc",  32'(errc),  32'h1);
    chk("t4_clr_voted", 32'(voted), 32'h00);
    cyc(8'h55, 8'h55, 8'h55, 1'b1, 1'b0);
    chk("t4_resume", 32'(voted), 32'h55);

    // T5: error counter saturation
    cyc(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b0;
    cyc(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc(8'h11, 8'h10, 8'h11, 1'b1, 1'b0);
      cyc(8'h11, 8'h10, 8'h11, 1'b1, 1'b0);
      chk("t5_state", 32'(state), 32'h2);
      chk("t5_errc",  32'(errc),  (i >= 3) ? 32'h3 : 32'(i));
      cyc(8'h11, 8'h11, 8'h11, 1'b1, 1'b1);
    end
    cyc(8'h11, 8'h11, 8'h11, 1'b1, 1'b0);
    rst_n = 1'b0;
    cyc(8'h11, 8'h10, 8'h11, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk_reset("t5_rst");

    // T6: clear beats a same-cycle mismatch; en_i gap keeps the run
    cyc(8'hA5, 8'hA5, 8'h00, 1'b1, 1'b0);
    cyc(8'hA5, 8'hA5, 8'h00, 1'b1, 1'b0);
    chk("t6_pre_fault", 32'(fault), 32'h1);
    cyc(8'hA5, 8'hA4, 8'hA5, 1'b1, 1'b1);
    chk("t6_clr_state", 32'(state), 32'h0);
    chk("t6_clr_fault", 32'(fault), 32'h0);
    chk("t6_clr_dmask", 32'(dmask), 32'h2);
    cyc(8'hA5, 8'hA4, 8'hA5, 1'b1, 1'b0);
    chk("t6_susp", 32'(state), 32'h1);
    cyc(8'h77, 8'h77, 8'h77, 1'b0, 1'b0);
    chk("t6_gap_state", 32'(state), 32'h1);
    chk("t6_gap_voted", 32'(voted), 32'hA5);
    chk("t6_gap_mism",  32'(mism),  32'h1);
    cyc(8'hA5, 8'hA4, 8'hA5, 1'b1, 1'b0);
    chk("t6_conf_state", 32'(state), 32'h2);
    chk("t6_conf_fch",   32'(fch),   32'h2);
    chk("t6_conf_errc",  32'(errc),  32'h2);

    // New channel failing while already in FAULT
    cyc(8'hA4, 8'hA5, 8'hA5, 1'b1, 1'b0);
    chk("t7_run_state", 32'(state), 32'h2);
    chk("t7_run_errc",  32'(errc),  32'h2);
    cyc(8'hA4, 8'hA5, 8'hA5, 1'b1, 1'b0);
    chk("t7_fch",  32'(fch),  32'h3);
    chk("t7_errc", 32'(errc), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
